alu_sliced: RTL and testbench
=============================

Name: alu_sliced

Overview:
- Parametrised successor to the 8-bit combinational Game Boy ALU. Executes the same 13-opcode set on WIDTH-bit operands, for example 16-bit ADD HL,rr and wide rotates.
- Processes operands serially, SLICE bits per clock, so only one SLICE-wide adder is instantiated.
- Sits between the register-file read port and the writeback stage.
- Valid/ready handshake on both input and output.

Parameters:
- WIDTH, 16, operand/result width. Must be a multiple of SLICE.
- SLICE, 8, bits processed per clock. Minimum 4.
- NSLICE, WIDTH/SLICE, derived; not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- regA  in  WIDTH  operand A
- regB  in  WIDTH  operand B
- opcode  in  4  ADD=0, ADC=1, SUB=2, SBC=3, CP=4, AND=5, OR=6, XOR=7, RL=8, RR=9, BSL=A, BSR=B, SWAP=C
- carryIn  in  1  carry flag input (ADC/SBC/RL/RR)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- res  out  WIDTH  result
- flagsOut  out  8  {Z,N,H,C,4'b0000}

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, res=0, flagsOut=0, internal operand/slice registers cleared. A request in flight is discarded.
- IDLE: in_ready=1. On in_valid&in_ready, capture regA, regB, opcode, carryIn; go to BUSY with slice counter=0.
- BUSY: in_ready=0. One slice per clock.
  - LSB-first for ADD/ADC/SUB/SBC/CP/logic/RL/BSL/SWAP.
  - MSB-first for RR/BSR.
  - Carry/borrow/shifted bit is registered between slices.
  - After slice NSLICE-1, go to DONE.
  - out_valid rises exactly NSLICE clocks after the accepting edge.
- DONE: out_valid=1; res/flagsOut held stable while out_ready=0. On out_valid&out_ready, go to IDLE; out_valid=0 next cycle.
  - in_ready is 0 in DONE, so a new request is accepted no earlier than the cycle after the output handshake.
- Arithmetic (all modulo 2^WIDTH):
  - ADC/SBC inject carryIn into slice 0; ADD/SUB/CP inject 0.
  - SUB/SBC/CP compute A-B-cin. C=borrow out of MSB.
  - CP: res=A (unchanged), flags as SUB.
  - H=carry (or borrow) out of bit 3 of the most-significant slice, i.e. bit WIDTH-SLICE+3. Bit 11 for the defaults.
  - N=1 for SUB/SBC/CP, else 0.
- Logic: AND gives H=1, C=0. OR/XOR give H=0, C=0. N=0 for all three.
- Shifts/rotates (operate on A only; N=H=0):
  - RL: res={A[W-2:0],cin}, C=A[W-1].
  - RR: res={cin,A[W-1:1]}, C=A[0].
  - BSL: res={A[W-2:0],0}, C=A[W-1].
  - BSR (logical): res={0,A[W-1:1]}, C=A[0].
- SWAP: res={A[W/2-1:0],A[W-1:W/2]}. N=H=C=0.
- Z=1 iff the full WIDTH-bit res==0. Z is evaluated over the whole word, never per slice.
- Illegal opcodes (D-F): same NSLICE latency, res=A, flagsOut=8'h00.
- in_valid held while busy: ignored; no second capture.
- Input changes after the capture edge have no effect on the result.

Test Plan (WIDTH=16, SLICE=8):
- ADD 0x0FFF+0x0001 -> res=0x1000, flags=0x20 (H). out_valid 2 clocks after accept.
- ADC 0xFFFF+0x0000, carryIn=1 -> res=0x0000, flags=0xB0 (Z,H,C).
- SBC 0x1000-0x0001, carryIn=1 -> res=0x0FFE, flags=0x60 (N,H). CP 0x1234 vs 0x1234 -> res=0x1234, flags=0xC0.
- RR 0x0001 carryIn=1 -> res=0x8000, flags=0x10. BSL 0x8000 -> res=0x0000, flags=0x90. SWAP 0x12AB -> res=0xAB12, flags=0x00.
- Backpressure: hold out_ready=0 for 5 clocks in DONE -> res/flags stable, in_ready=0. Toggle in_valid during this window -> no capture. Release -> out_valid drops next cycle and in_ready=1.
- Assert rst mid-BUSY (after slice 0) -> outputs immediately 0, state IDLE. Next request completes correctly. Run 200 random ADC/SBC ops against a reference model for res and flags.

Source files
------------

// File: rtl/alu_sliced.sv
// Serial Game Boy-style ALU: WIDTH-bit operands processed SLICE bits per clock
// through one SLICE-wide adder, valid/ready handshake on both sides.
module alu_sliced #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] regA,
    input  logic [WIDTH-1:0] regB,
    input  logic [3:0]       opcode,
    input  logic             carryIn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [7:0]       flagsOut
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int unsigned IW     = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADC  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_SBC  = 4'h3;
    localparam logic [3:0] OP_CP   = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_RL   = 4'h8;
    localparam logic [3:0] OP_RR   = 4'h9;
    localparam logic [3:0] OP_BSL  = 4'hA;
    localparam logic [3:0] OP_BSR  = 4'hB;
    localparam logic [3:0] OP_SWAP = 4'hC;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_n;
    logic [WIDTH-1:0]  a_q, b_q, res_q, res_n;
    logic [3:0]        op_q;
    logic              cry_q, cry_n;
    logic              nz_q;
    logic [CW-1:0]     cnt_q, idx;
    logic [7:0]        flags_q, flags_n;

    logic              last, accept, msb_first, is_sub, is_arith, is_shift;
    logic [IW-1:0]     sh;
    logic [WIDTH-1:0]  swp;
    logic [SLICE-1:0]  a_s, b_s, bx, val, wr;
    logic [SLICE:0]    a_e, bx_e, sum;
    logic              h_bit, z_f, h_f, c_f;

    assign last   = (cnt_q == CW'(NSLICE - 1));
    assign accept = in_valid && in_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE: if (in_valid) state_n = BUSY;
            BUSY: if (last) state_n = DONE;
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: in_ready  = 1'b1;
            DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // Slice datapath: RR/BSR walk MSB-first so the shifted-in bit flows downward
    always_comb begin
        msb_first = (op_q == OP_RR) || (op_q == OP_BSR);
        is_sub    = (op_q == OP_SUB) || (op_q == OP_SBC) || (op_q == OP_CP);
        is_arith  = (op_q <= OP_CP);
        is_shift  = (op_q >= OP_RL) && (op_q <= OP_BSR);
        idx       = msb_first ? (CW'(NSLICE - 1) - cnt_q) : cnt_q;
        sh        = IW'(idx) * IW'(SLICE);
        swp       = {a_q[WIDTH/2-1:0], a_q[WIDTH-1:WIDTH/2]};
        a_s       = a_q[sh +: SLICE];
        b_s       = b_q[sh +: SLICE];
        bx        = is_sub ? ~b_s : b_s;
        a_e       = {1'b0, a_s};
        bx_e      = {1'b0, bx};
        sum       = a_e + bx_e + (SLICE+1)'(cry_q ^ is_sub);
        // carry into bit 4 recovered from the sum, no second adder
        h_bit     = sum[4] ^ a_e[4] ^ bx_e[4] ^ is_sub;
        cry_n     = cry_q;
        val       = a_s;
        case (op_q)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CP: begin
                val   = sum[SLICE-1:0];
                cry_n = sum[SLICE] ^ is_sub;
            end
            OP_AND:  val = a_s & b_s;
            OP_OR:   val = a_s | b_s;
            OP_XOR:  val = a_s ^ b_s;
            OP_RL, OP_BSL: begin
                val   = {a_s[SLICE-2:0], cry_q};
                cry_n = a_s[SLICE-1];
            end
            OP_RR, OP_BSR: begin
                val   = {cry_q, a_s[SLICE-1:1]};
                cry_n = a_s[0];
            end
            OP_SWAP: val = swp[sh +: SLICE];
            default: val = a_s;
        endcase
        wr            = (op_q == OP_CP) ? a_s : val;
        res_n         = res_q;
        res_n[sh +: SLICE] = wr;
    end

    // Final flags; Z covers the whole word via the running nonzero accumulator
    always_comb begin
        z_f     = ~(nz_q | (|val));
        h_f     = is_arith ? h_bit : (op_q == OP_AND);
        c_f     = (is_arith || is_shift) ? cry_n : 1'b0;
        flags_n = 8'h00;
        if (op_q <= OP_SWAP) flags_n = {z_f, is_sub, h_f, c_f, 4'b0000};
    end

    // Operand capture and per-slice accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cry_q   <= 1'b0;
            nz_q    <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    a_q   <= regA;
                    b_q   <= regB;
                    op_q  <= opcode;
                    cry_q <= ((opcode == OP_ADC) || (opcode == OP_SBC) ||
                              (opcode == OP_RL)  || (opcode == OP_RR)) ? carryIn : 1'b0;
                    nz_q  <= 1'b0;
                    cnt_q <= '0;
                end
                BUSY: begin
                    res_q <= res_n;
                    cry_q <= cry_n;
                    nz_q  <= nz_q | (|val);
                    cnt_q <= cnt_q + CW'(1);
                    if (last) flags_q <= flags_n;
                end
                default: ;
            endcase
        end
    end

    assign res      = res_q;
    assign flagsOut = flags_q;

endmodule

// File: tb/tb_alu_sliced.sv
// Self-checking bench for alu_sliced: constant vector table, backpressure and
// mid-operation reset sequences, and random ADC/SBC against a reference model.
module tb_alu_sliced;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned SLICE  = 8;
    localparam int unsigned NSLICE = WIDTH / SLICE;

    logic             clk, rst, in_valid, in_ready, out_valid, out_ready, carryIn;
    logic [WIDTH-1:0] regA, regB, res;
    logic [3:0]       opcode;
    logic [7:0]       flagsOut;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic [7:0]       flags;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [3:0]       op;
        logic             cin;
        logic [WIDTH-1:0] res;
        logic [7:0]       flags;
    } vec_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    alu_sliced #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .regA(regA), .regB(regB), .opcode(opcode), .carryIn(carryIn),
        .out_valid(out_valid), .out_ready(out_ready), .res(res), .flagsOut(flagsOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [3:0] op, input logic cin);
        exp_t             e;
        logic [WIDTH:0]   r;
        logic [WIDTH-1:0] x;
        logic             c, z, n, h, cf;
        n = 1'b0; h = 1'b0; cf = 1'b0;
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin
                c = (op == 4'h1 || op == 4'h3) ? cin : 1'b0;
                n = (op >= 4'h2);
                if (n) r = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(c);
                else   r = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(c);
                x  = a ^ b ^ r[WIDTH-1:0];
                h  = x[WIDTH-SLICE+4];
                cf = r[WIDTH];
                z  = (r[WIDTH-1:0] == '0);
                e.res = (op == 4'h4) ? a : r[WIDTH-1:0];
            end
            4'h5: begin e.res = a & b; h = 1'b1; z = (e.res == '0); end
            4'h6: begin e.res = a | b; z = (e.res == '0); end
            4'h7: begin e.res = a ^ b; z = (e.res == '0); end
            4'h8: begin e.res = {a[WIDTH-2:0], cin};  cf = a[WIDTH-1]; z = (e.res == '0); end
            4'h9: begin e.res = {cin, a[WIDTH-1:1]};  cf = a[0];       z = (e.res == '0); end
            4'hA: begin e.res = {a[WIDTH-2:0], 1'b0}; cf = a[WIDTH-1]; z = (e.res == '0); end
            4'hB: begin e.res = {1'b0, a[WIDTH-1:1]}; cf = a[0];       z = (e.res == '0); end
            4'hC: begin e.res = {a[WIDTH/2-1:0], a[WIDTH-1:WIDTH/2]}; z = (e.res == '0); end
            default: begin e.res = a; z = 1'b0; end
        endcase
        e.flags = {z, n, h, cf, 4'b0000};
        return e;
    endfunction

    // Called on a negedge; returns on the negedge following the accepting edge
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [3:0] op, input logic cin);
        int t = 0;
        while (!in_ready && t < 50) begin @(negedge clk); t++; end
        chk("in_ready_before_issue", 32'(in_ready), 32'd1);
        regA = a; regB = b; opcode = op; carryIn = cin; in_valid = 1'b1;
        @(posedge clk);
        sb.push_back(model(a, b, op, cin));
        @(negedge clk);
        in_valid = 1'b0;
        regA = WIDTH'($urandom); regB = WIDTH'($urandom);
        opcode = 4'($urandom); carryIn = 1'($urandom);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        chk("latency", 32'(lat), 32'(NSLICE));
    endtask

    task automatic compare_head(output exp_t e);
        if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL scoreboard: empty when output appeared");
            e.res = '0; e.flags = '0;
        end else begin
            e = sb.pop_front();
            chk("res", 32'(res), 32'(e.res));
            chk("flags", 32'(flagsOut), 32'(e.flags));
        end
    endtask

    task automatic collect();
        int   lat;
        exp_t e;
        wait_out(lat);
        compare_head(e);
        @(posedge clk); @(negedge clk);
        chk("out_valid_drop", 32'(out_valid), 32'd0);
        chk("in_ready_after", 32'(in_ready), 32'd1);
    endtask

    vec_t vt[16];

    initial begin
        int   lat;
        exp_t e;
        logic [WIDTH-1:0] hr;
        logic [7:0]       hf;

        vt[0]  = '{16'h0FFF, 16'h0001, 4'h0, 1'b0, 16'h1000, 8'h20};
        vt[1]  = '{16'hFFFF, 16'h0000, 4'h1, 1'b1, 16'h0000, 8'hB0};
        vt[2]  = '{16'h1000, 16'h0001, 4'h3, 1'b1, 16'h0FFE, 8'h60};
        vt[3]  = '{16'h1234, 16'h1234, 4'h4, 1'b0, 16'h1234, 8'hC0};
        vt[4]  = '{16'h0001, 16'h0000, 4'h9, 1'b1, 16'h8000, 8'h10};
        vt[5]  = '{16'h8000, 16'h0000, 4'hA, 1'b0, 16'h0000, 8'h90};
        vt[6]  = '{16'h12AB, 16'h0000, 4'hC, 1'b0, 16'hAB12, 8'h00};
        vt[7]  = '{16'hF0F0, 16'h0FF0, 4'h5, 1'b0, 16'h00F0, 8'h20};
        vt[8]  = '{16'h0000, 16'h0000, 4'h6, 1'b0, 16'h0000, 8'h80};
        vt[9]  = '{16'hFFFF, 16'hFFFF, 4'h7, 1'b0, 16'h0000, 8'h80};
        vt[10] = '{16'h8001, 16'h0000, 4'h8, 1'b0, 16'h0002, 8'h10};
        vt[11] = '{16'h0003, 16'h0000, 4'hB, 1'b0, 16'h0001, 8'h10};
        vt[12] = '{16'h0000, 16'h0001, 4'h2, 1'b0, 16'hFFFF, 8'h70};
        vt[13] = '{16'h0000, 16'h0000, 4'hD, 1'b1, 16'h0000, 8'h00};
        vt[14] = '{16'h8000, 16'h8000, 4'h0, 1'b0, 16'h0000, 8'h90};
        vt[15] = '{16'h4000, 16'h0000, 4'h8, 1'b0, 16'h8000, 8'h00};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        regA = '0; regB = '0; opcode = '0; carryIn = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_res", 32'(res), 32'd0);
        chk("rst_flags", 32'(flagsOut), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Table vectors: DUT against both the constant and the model
        for (int i = 0; i < 16; i++) begin
            issue(vt[i].a, vt[i].b, vt[i].op, vt[i].cin);
            wait_out(lat);
            chk($sformatf("vec%0d_res", i), 32'(res), 32'(vt[i].res));
            chk($sformatf("vec%0d_flags", i), 32'(flagsOut), 32'(vt[i].flags));
            compare_head(e);
            @(posedge clk); @(negedge clk);
            chk("out_valid_drop", 32'(out_valid), 32'd0);
            chk("in_ready_after", 32'(in_ready), 32'd1);
        end

        // Backpressure: hold in DONE, wiggle in_valid, expect no capture
        out_ready = 1'b0;
        issue(16'h0FFF, 16'h0001, 4'h0, 1'b0);
        wait_out(lat);
        hr = res; hf = flagsOut;
        compare_head(e);
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0]; regA = WIDTH'($urandom); opcode = 4'h7;
            @(posedge clk); @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_res_stable", 32'(res), 32'(hr));
            chk("bp_flags_stable", 32'(flagsOut), 32'(hf));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        repeat (3) @(negedge clk);
        chk("bp_no_capture", 32'(out_valid), 32'd0);
        chk("bp_res_after", 32'(res), 32'(hr));

        // Reset after slice 0 discards the request
        issue(16'hFFFF, 16'h0001, 4'h0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_res", 32'(res), 32'd0);
        chk("mid_rst_flags", 32'(flagsOut), 32'd0);
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(16'h1000, 16'h0001, 4'h3, 1'b1);
        collect();

        // Random ADC/SBC
        for (int i = 0; i < 200; i++) begin
            issue(WIDTH'($urandom), WIDTH'($urandom), ($urandom_range(0, 1) != 0) ? 4'h1 : 4'h3,
                  1'($urandom));
            collect();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
